// File: rtl/uart_pkg.sv
// Shared types and defaults for the console UART transmit path.
// Imported by the FIFO, the controller and the serialiser.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } uart_ctrl_state_t;

  localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a one-cycle flush.
// rdata shows the head entry combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index, different wrap bit means every slot is occupied.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (flush)       rd_ptr <= wr_ptr;
      else if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: start bit, LSB-first data, stop bit.
// tx_done pulses for one cycle as tx_busy falls.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tx_start,
  input  byte_t tx_data,
  output logic  tx_busy,
  output logic  tx_done,
  output logic  tx_line
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;

  logic [8:0]    shreg;
  logic [3:0]    bit_idx;
  logic [CW-1:0] ck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_line <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
      ck      <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          tx_busy <= 1'b1;
          shreg   <= {1'b1, tx_data};
          tx_line <= 1'b0;
          bit_idx <= '0;
          ck      <= '0;
        end
      end else if (ck != CW'(CLKS_PER_BIT - 1)) begin
        ck <= ck + 1'b1;
      end else begin
        ck <= '0;
        if (bit_idx == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
          tx_line <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 1'b1;
          tx_line <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Console transmit controller: queues CPU bytes and feeds uart_tx
// one at a time, with optional inter-byte gap and drain status.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic                          flush,
  output logic                          uart_start,
  output logic [7:0]                    uart_data,
  input  logic                          uart_busy,
  input  logic                          uart_done,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          idle,
  output logic                          drain_irq,
  output logic [CNT_W-1:0]              sent_cnt
);

  localparam int GW = (GAP_CYCLES > 1) ?
                      $clog2(GAP_CYCLES) : 1;

  uart_ctrl_state_t state, state_d;
  byte_t            head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_fire;
  logic             done_evt;
  logic             gap_last;
  logic [GW-1:0]    gap_cnt;

  assign wr_ready = !full;
  assign wr_fire  = wr_valid && !full && !flush;
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_valid),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    state_d    = state;
    pop        = 1'b0;
    done_evt   = 1'b0;
    uart_start = 1'b0;
    idle       = 1'b0;
    unique case (state)
      IDLE: begin
        idle = empty && !uart_busy;
        if (!empty && !uart_busy && !flush) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        uart_start = 1'b1;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (uart_done) begin
          done_evt = 1'b1;
          state_d  = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write landing with tx_done keeps the queue non-empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      uart_data <= '0;
      gap_cnt   <= '0;
      sent_cnt  <= '0;
      drain_irq <= 1'b0;
    end else begin
      state     <= state_d;
      drain_irq <= done_evt && empty && !wr_fire;
      if (pop)      uart_data <= head;
      if (done_evt) sent_cnt  <= sent_cnt + 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule
